bram_arbiter: RTL
=================

// Module: bram_arbiter
// PURPOSE
//  Shares the single-port bram between the instruction-fetch port (imem) and the load/store port (dmem).
//  Holds one pending request per port and issues one bram access at a time.
//  Routes bram_rdata/bram_ready back to the port that owns the access.
//  Sits between the core's fetch/LSU and bram in the testbench/SoC top.
// PARAMETERS
//  PRIO_DATA  1  fixed-priority winner on contention when BRAM_ARB_RR_EN undefined (1=dmem, 0=imem)
// PORTS
//  clock       in   1   system clock, all state on rising edge
//  reset       in   1   asynchronous, active-low reset
//  imem_valid  in   1   one-cycle request pulse, fetch port
//  imem_instr  in   1   request is instruction fetch (forwarded as bram_instr)
//  imem_addr   in   32  byte address
//  imem_wdata  in   32  write data
//  imem_wstrb  in   4   byte strobes (0 = read)
//  imem_rdata  out  32  read data, valid when imem_ready=1
//  imem_ready  out  1   one-cycle completion pulse
//  dmem_*      --   --  identical set for load/store port
//  bram_valid  out  1   one-cycle access pulse to bram
//  bram_instr  out  1   forwarded instr flag of granted request
//  bram_addr   out  32  registered address of granted request
//  bram_wdata  out  32  registered write data
//  bram_wstrb  out  4   registered strobes
//  bram_rdata  in   32  bram read data
//  bram_ready  in   1   bram completion pulse (>=1 cycle after bram_valid)
//  arb_error   out  1   sticky: request arrived while same port already outstanding
// BEHAVIOUR
//  - Reset (reset=0, async): FSM=IDLE, both pending regs empty, bram_valid=0, bram_addr/wdata/wstrb=0,
//    bram_instr=0, imem_ready=dmem_ready=0, arb_error=0, rr pointer=imem-last. In-flight access dropped, no ready issued.
//  - Capture: x_valid=1 with port x free -> request latched into pend_x at that edge.
//  - FSM IDLE: if any pend set -> choose winner, drive bram_* from its pend reg, bram_valid=1 for exactly 1 cycle,
//    go BUSY_I or BUSY_D. Capture and issue happen in the same cycle only via the registered pend (no bypass).
//  - BUSY_x: wait for bram_ready (any number of cycles); on bram_ready: x_ready=1 (1 cycle),
//    x_rdata=bram_rdata (combinational pass-through), clear pend_x, go IDLE.
//    Other port's x_ready stays 0; x_rdata of the non-owner is don't-care (drive 0).
//  - Latency uncontended: valid @N -> bram_valid @N+1 -> bram_ready @N+2 -> x_ready @N+2 (2 cycles).
//    The loser of a collision sees ready at N+4 with a 1-cycle bram.
//  - bram_ready in IDLE: ignored.
//  - Port free again in the cycle its x_ready=1: a new x_valid that cycle is accepted.
//  - x_valid while pend_x set (protocol violation): new request dropped, arb_error set until reset.
//  - Writes: wstrb forwarded unchanged; ready/rdata semantics identical to reads.
// CONFIGURATION
//  BRAM_ARB_RR_EN defined: round-robin on contention; the port not granted last wins; pointer updates at each grant.
//  BRAM_ARB_RR_EN undefined: fixed priority per PRIO_DATA; starvation is possible and accepted.
// STRUCTURE
//  - configure package: bram_req_t struct {instr, addr[31:0], wdata[31:0], wstrb[3:0]}.
//  - configure package: arb_state_t enum {IDLE, BUSY_I, BUSY_D}; existing bram_depth unchanged.
//  - Sub-module bram_arb_slot (x2): one-entry pending register with capture/clear/error logic.
//  - Top-level FSM, grant select and response mux stay in bram_arbiter.
// TESTING
//  - Single read: imem_valid @N, addr=0x80, bram word=0xDEADBEEF -> bram_valid @N+1 addr=0x80, imem_ready+rdata=0xDEADBEEF @N+2.
//  - Collision, RR undefined, PRIO_DATA=1: both valid @N -> dmem served first (ready N+2), imem ready N+4; order verified by bram_addr.
//  - Collision, BRAM_ARB_RR_EN: 4 back-to-back collisions -> grants alternate D,I,D,I (first after reset is D).
//  - Write: dmem addr=0x100 wdata=0x12345678 wstrb=4'b0011 -> bram_wstrb=4'b0011, dmem_ready 1 cycle; imem read 0x100 low half=0x5678.
//  - Slow bram: bram_ready held off 5 cycles -> FSM stays BUSY, no other bram_valid, single ready on arrival.
//  - Violation + reset: second imem_valid while pending -> arb_error=1; reset low mid-BUSY -> all outputs 0, no ready after release.

Source files
------------

// File: rtl/bram_arbiter_pkg.sv
// Shared types for the imem/dmem bram arbiter: request payload, FSM state encoding.
package bram_arbiter_pkg;

   localparam int BRAM_DEPTH = 4096;

   typedef struct packed {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } bram_req_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_t;

   localparam bram_req_t REQ_NONE = '0;

endpackage

// File: rtl/bram_arbiter_if.sv
// Request/response bundle used for the fetch port, the load/store port and the bram side.
interface bram_arbiter_if;

   logic        valid;
   logic        instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;

   modport master (output valid, instr, addr, wdata, wstrb, input  rdata, ready);
   modport slave  (input  valid, instr, addr, wdata, wstrb, output rdata, ready);

endinterface

// File: rtl/bram_arb_slot.sv
// One-entry pending request register for one arbiter port, with sticky overrun error.
module bram_arb_slot
   import bram_arbiter_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      i_valid,
   input  bram_req_t i_req,
   input  logic      i_clear,
   output logic      o_pend,
   output bram_req_t o_req,
   output logic      o_error
);

   logic      r_pend;
   bram_req_t r_req;
   logic      r_error;
   logic      w_free;
   logic      w_capture;

   // The slot frees up in the same cycle its response is delivered.
   assign w_free    = !r_pend || i_clear;
   assign w_capture = i_valid && w_free;

   // NOTE: state updates use <= so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pend  <= 1'b0;
         // NOTE: the payload is reset too, so the bram bus reads all-zero straight out of reset.
         r_req   <= REQ_NONE;
         r_error <= 1'b0;
      end else begin
         if (w_capture) begin
            r_pend <= 1'b1;
            r_req  <= i_req;
         end else if (i_clear) begin
            r_pend <= 1'b0;
         end
         if (i_valid && !w_free) begin
            r_error <= 1'b1;
         end
      end
   end

   assign o_pend  = r_pend;
   assign o_req   = r_req;
   assign o_error = r_error;

endmodule

// File: rtl/bram_arbiter.sv
// Shares a single-port bram between fetch (imem) and load/store (dmem) ports.
// Contention policy: fixed priority via PRIO_DATA, or round-robin when BRAM_ARB_RR_EN is defined.
module bram_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter bit PRIO_DATA = 1'b1
) (
   input  logic           clock,
   input  logic           reset,
   bram_arbiter_if.slave  imem,
   bram_arbiter_if.slave  dmem,
   bram_arbiter_if.master bram,
   output logic           arb_error
);

   arb_state_t r_state;
   bram_req_t  w_req_i_in, w_req_d_in;
   bram_req_t  w_req_i, w_req_d;
   bram_req_t  w_sel;
   logic       w_pend_i, w_pend_d;
   logic       w_err_i, w_err_d;
   logic       w_done_i, w_done_d;
   logic       w_any, w_grant_d, w_issue;

   assign w_req_i_in = '{instr: imem.instr, addr: imem.addr, wdata: imem.wdata, wstrb: imem.wstrb};
   assign w_req_d_in = '{instr: dmem.instr, addr: dmem.addr, wdata: dmem.wdata, wstrb: dmem.wstrb};

   assign w_done_i = (r_state == BUSY_I) && bram.ready;
   assign w_done_d = (r_state == BUSY_D) && bram.ready;

   bram_arb_slot u_slot_i (
      .clock   (clock),
      .reset   (reset),
      .i_valid (imem.valid),
      .i_req   (w_req_i_in),
      .i_clear (w_done_i),
      .o_pend  (w_pend_i),
      .o_req   (w_req_i),
      .o_error (w_err_i)
   );

   bram_arb_slot u_slot_d (
      .clock   (clock),
      .reset   (reset),
      .i_valid (dmem.valid),
      .i_req   (w_req_d_in),
      .i_clear (w_done_d),
      .o_pend  (w_pend_d),
      .o_req   (w_req_d),
      .o_error (w_err_d)
   );

   assign w_any   = w_pend_i || w_pend_d;
   assign w_issue = (r_state == IDLE) && w_any;

`ifdef BRAM_ARB_RR_EN
   logic r_last_d;
   assign w_grant_d = w_pend_d && (!w_pend_i || !r_last_d);
`else
   assign w_grant_d = w_pend_d && (!w_pend_i || PRIO_DATA);
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
`ifdef BRAM_ARB_RR_EN
         r_last_d <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state <= w_grant_d ? BUSY_D : BUSY_I;
`ifdef BRAM_ARB_RR_EN
                  r_last_d <= w_grant_d;
`endif
               end
            end
            BUSY_I:  if (bram.ready) r_state <= IDLE;
            BUSY_D:  if (bram.ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // The bram bus is a mux of already-registered pend payloads, keeping issue one cycle after capture.
   always_comb begin
      // NOTE: default first so every path assigns w_sel and no latch is inferred.
      w_sel = REQ_NONE;
      case (r_state)
         IDLE:    if (w_any) w_sel = w_grant_d ? w_req_d : w_req_i;
         BUSY_I:  w_sel = w_req_i;
         BUSY_D:  w_sel = w_req_d;
         default: w_sel = REQ_NONE;
      endcase
   end

   assign bram.valid = w_issue;
   assign bram.instr = w_sel.instr;
   assign bram.addr  = w_sel.addr;
   assign bram.wdata = w_sel.wdata;
   assign bram.wstrb = w_sel.wstrb;

   assign imem.ready = w_done_i;
   assign dmem.ready = w_done_d;
   assign imem.rdata = (r_state == BUSY_I) ? bram.rdata : 32'h0;
   assign dmem.rdata = (r_state == BUSY_D) ? bram.rdata : 32'h0;

   assign arb_error = w_err_i || w_err_d;

endmodule
